// File: rtl/dii_packet_arbiter_pkg.sv
// Shared DII definitions: flit width, flit channel struct and arbiter FSM states.
package dii_packet_arbiter_pkg;

    localparam int FLIT_W = 16;

    // Arbiter FSM encoding: IDLE = no packet open, LOCKED = packet open from grant_port.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // One flit travelling on a DII channel.
    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic              first;
        logic              last;
    } dii_channel;

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// DII arbiter bus: flattened per-port request channels plus the arbitrated output.
// Handshake: a flit moves on a channel in any cycle where its valid and ready are
// both high; a source holds valid and payload stable until that cycle.
interface dii_packet_arbiter_if #(
    parameter int PORTS = 2
);
    import dii_packet_arbiter_pkg::*;

    localparam int IDX_W = $clog2(PORTS);

    logic [PORTS*FLIT_W-1:0] in_flat_data;
    logic [PORTS-1:0]        in_flat_valid;
    logic [PORTS-1:0]        in_flat_first;
    logic [PORTS-1:0]        in_flat_last;
    logic [PORTS-1:0]        in_flat_ready;
    logic [FLIT_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_first;
    logic                    out_last;
    logic                    out_ready;
    logic [IDX_W-1:0]        grant_port;
    logic                    locked;

    // Requesters and downstream sink side.
    modport master (
        output in_flat_data, in_flat_valid, in_flat_first, in_flat_last, out_ready,
        input  in_flat_ready, out_data, out_valid, out_first, out_last, grant_port, locked
    );

    // Arbiter side.
    modport slave (
        input  in_flat_data, in_flat_valid, in_flat_first, in_flat_last, out_ready,
        output in_flat_ready, out_data, out_valid, out_first, out_last, grant_port, locked
    );

endinterface

// File: rtl/dii_packet_arbiter_reg_slice.sv
// dii_reg_slice: single-entry output register; accepts when empty or draining.
module dii_reg_slice
    import dii_packet_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  dii_channel in_flit,
    output logic       out_valid,
    input  logic       out_ready,
    output dii_channel out_flit
);

    logic       valid_q, valid_d;
    dii_channel flit_q, flit_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_flit  = flit_q;

    // Load a new flit whenever the slot is free or being emptied this cycle.
    always_comb begin
        valid_d = valid_q;
        flit_d  = flit_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                flit_d = in_flit;
            end
        end
    end

    // Register with asynchronous clear so no stale flit survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-locking round-robin arbiter merging PORTS DII channels into one.
module dii_packet_arbiter
    import dii_packet_arbiter_pkg::*;
#(
    parameter  int PORTS = 2,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    dii_packet_arbiter_if.slave bus,
    output logic [0:0]       dbg_state,
    output logic [IDX_W-1:0] dbg_rr_ptr
);

    // First valid port at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_search(input logic [PORTS-1:0] valid,
                                                 input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < PORTS; i++) begin
            j = int'(ptr) + i;
            if (j >= PORTS) j = j - PORTS;
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]   search;
    logic [IDX_W-1:0] winner;
    logic             eligible;
    logic             accept;
    logic             xfer;
    logic [PORTS-1:0] ready_vec;
    logic             slice_in_ready;
    dii_channel       win_flit;
    dii_channel       out_flit;

    // Pick the eligible port, steer its flit to the slice and advance FSM/pointer.
    always_comb begin
        search    = rr_search(bus.in_flat_valid, rr_ptr_q);
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        ready_vec = '0;
        if (state_q == ST_LOCKED) begin
            winner   = grant_q;
            eligible = 1'b1;
        end else begin
            winner   = search[IDX_W-1:0];
            eligible = search[IDX_W];
        end
        win_flit.data  = bus.in_flat_data[int'(winner)*FLIT_W +: FLIT_W];
        win_flit.first = bus.in_flat_first[winner];
        win_flit.last  = bus.in_flat_last[winner];
        // Ready is forced low while reset is asserted, independent of the clock.
        accept = rst & slice_in_ready;
        xfer   = eligible & bus.in_flat_valid[winner] & accept;
        if (eligible && accept) begin
            ready_vec[winner] = 1'b1;
        end
        if (xfer) begin
            if (win_flit.last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (winner == IDX_W'(PORTS-1)) ? '0 : winner + 1'b1;
            end else if (state_q == ST_IDLE) begin
                // The first flag is ignored: any non-last flit in IDLE opens a packet.
                state_d = ST_LOCKED;
                grant_d = winner;
            end
        end
    end

    // Arbitration state, cleared asynchronously so the next search starts at port 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    dii_reg_slice u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (xfer),
        .in_ready  (slice_in_ready),
        .in_flit   (win_flit),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_flit  (out_flit)
    );

    assign bus.in_flat_ready = ready_vec;
    assign bus.out_data      = out_flit.data;
    assign bus.out_first     = out_flit.first;
    assign bus.out_last      = out_flit.last;
    assign bus.grant_port    = grant_q;
    assign bus.locked        = (state_q == ST_LOCKED);
    assign dbg_state         = state_q;
    assign dbg_rr_ptr        = rr_ptr_q;

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed bench for dii_packet_arbiter: a 2-port and a 4-port instance.
module tb_dii_packet_arbiter;
    import dii_packet_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [0:0] st_a, st_b;
    logic [0:0] rr_a;
    logic [1:0] rr_b;

    dii_packet_arbiter_if #(.PORTS(2)) ifa ();
    dii_packet_arbiter_if #(.PORTS(4)) ifb ();

    dii_packet_arbiter #(.PORTS(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifa.slave),
        .dbg_state  (st_a),
        .dbg_rr_ptr (rr_a)
    );

    dii_packet_arbiter #(.PORTS(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifb.slave),
        .dbg_state  (st_b),
        .dbg_rr_ptr (rr_b)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int p, input logic v, input logic [15:0] d,
                           input logic f, input logic l);
        ifa.in_flat_valid[p]         = v;
        ifa.in_flat_data[p*16 +: 16] = d;
        ifa.in_flat_first[p]         = f;
        ifa.in_flat_last[p]          = l;
    endtask

    task automatic drive_b(input int p, input logic v, input logic [15:0] d,
                           input logic f, input logic l);
        ifb.in_flat_valid[p]         = v;
        ifb.in_flat_data[p*16 +: 16] = d;
        ifb.in_flat_first[p]         = f;
        ifb.in_flat_last[p]          = l;
    endtask

    // Compare one instance's outputs against expectations (payload only when valid).
    task automatic expect_out(input string tag, input int inst, input logic [3:0] rdy,
                              input logic ov, input logic [15:0] od, input logic of,
                              input logic ol, input logic lk, input logic [1:0] gp,
                              input logic [1:0] rr);
        logic [3:0]  o_rdy;
        logic        o_ov, o_of, o_ol, o_lk, o_st;
        logic [15:0] o_od;
        logic [1:0]  o_gp, o_rr;
        if (inst == 0) begin
            o_rdy = {2'b00, ifa.in_flat_ready};
            o_ov = ifa.out_valid; o_od = ifa.out_data; o_of = ifa.out_first; o_ol = ifa.out_last;
            o_lk = ifa.locked; o_gp = {1'b0, ifa.grant_port}; o_rr = {1'b0, rr_a}; o_st = st_a[0];
        end else begin
            o_rdy = ifb.in_flat_ready;
            o_ov = ifb.out_valid; o_od = ifb.out_data; o_of = ifb.out_first; o_ol = ifb.out_last;
            o_lk = ifb.locked; o_gp = ifb.grant_port; o_rr = rr_b; o_st = st_b[0];
        end
        check({tag, "/ready"}, 32'(o_rdy), 32'(rdy));
        check({tag, "/out_valid"}, 32'(o_ov), 32'(ov));
        if (ov) begin
            check({tag, "/out_data"}, 32'(o_od), 32'(od));
            check({tag, "/out_first"}, 32'(o_of), 32'(of));
            check({tag, "/out_last"}, 32'(o_ol), 32'(ol));
        end
        check({tag, "/locked"}, 32'(o_lk), 32'(lk));
        check({tag, "/state"}, 32'(o_st), 32'(lk));
        if (lk) check({tag, "/grant_port"}, 32'(o_gp), 32'(gp));
        check({tag, "/rr_ptr"}, 32'(o_rr), 32'(rr));
    endtask

    // Every output must read zero while reset is held.
    task automatic expect_reset(input string tag, input int inst);
        expect_out(tag, inst, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        if (inst == 0) begin
            check({tag, "/out_data0"}, 32'(ifa.out_data), 32'h0);
            check({tag, "/flags0"}, 32'({ifa.out_first, ifa.out_last}), 32'h0);
            check({tag, "/grant0"}, 32'(ifa.grant_port), 32'h0);
        end else begin
            check({tag, "/out_data0"}, 32'(ifb.out_data), 32'h0);
            check({tag, "/flags0"}, 32'({ifb.out_first, ifb.out_last}), 32'h0);
            check({tag, "/grant0"}, 32'(ifb.grant_port), 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        ifa.in_flat_data = '0; ifa.in_flat_valid = '0; ifa.in_flat_first = '0; ifa.in_flat_last = '0;
        ifb.in_flat_data = '0; ifb.in_flat_valid = '0; ifb.in_flat_first = '0; ifb.in_flat_last = '0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        // Requests present during reset must not be granted.
        drive_a(0, 1'b1, 16'h00A0, 1'b1, 1'b1);
        drive_a(1, 1'b1, 16'h00B1, 1'b1, 1'b1);
        @(negedge clk);
        expect_reset("rst_a", 0);
        expect_reset("rst_b", 1);
        step();
        rst = 1'b1;

        // Two ports streaming single flits alternate one per cycle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expect_out($sformatf("alt%0d", k), 0, (k % 2 == 0) ? 4'b0001 : 4'b0010,
                       k > 0, (k % 2 == 1) ? 16'h00A0 : 16'h00B1, 1'b1, 1'b1,
                       1'b0, 2'd0, 2'(k % 2));
            step();
        end
        drive_a(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_a(1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("alt_drain", 0, 4'b0000, 1'b1, 16'h00B1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        @(negedge clk);
        expect_out("alt_empty", 0, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();

        // 4-flit packet on port0 locks out a pending single flit on port1.
        drive_a(1, 1'b1, 16'h2000, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive_a(0, 1'b1, 16'h1000 + 16'(k), k == 0, k == 3);
            @(negedge clk);
            expect_out($sformatf("lock%0d", k), 0, 4'b0001, k > 0, 16'h1000 + 16'(k) - 16'd1,
                       k == 1, 1'b0, k > 0, 2'd0, 2'd0);
            step();
        end
        drive_a(0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("lock_tail", 0, 4'b0010, 1'b1, 16'h1003, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
        step();
        drive_a(1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("lock_p1", 0, 4'b0000, 1'b1, 16'h2000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        @(negedge clk);
        expect_out("lock_empty", 0, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();

        // Downstream stall mid-packet holds output, lock and pointer.
        drive_a(1, 1'b1, 16'h2222, 1'b1, 1'b1);
        drive_a(0, 1'b1, 16'h3000, 1'b1, 1'b0);
        @(negedge clk);
        expect_out("stall0", 0, 4'b0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        drive_a(0, 1'b1, 16'h3001, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("stall1", 0, 4'b0001, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
        step();
        drive_a(0, 1'b1, 16'h3002, 1'b0, 1'b0);
        ifa.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_out($sformatf("stall_hold%0d", k), 0, 4'b0000, 1'b1, 16'h3001, 1'b0, 1'b0,
                       1'b1, 2'd0, 2'd0);
            step();
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        expect_out("stall_resume", 0, 4'b0001, 1'b1, 16'h3001, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        step();
        drive_a(0, 1'b1, 16'h3003, 1'b0, 1'b1);
        @(negedge clk);
        expect_out("stall_last", 0, 4'b0001, 1'b1, 16'h3002, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        step();
        drive_a(0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("stall_tail", 0, 4'b0010, 1'b1, 16'h3003, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
        step();
        drive_a(1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("stall_p1", 0, 4'b0000, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        @(negedge clk);
        expect_out("stall_empty", 0, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();

        // Reset in the middle of a port1 packet, with rr_ptr moved off zero first.
        drive_a(0, 1'b1, 16'h4000, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("mrst0", 0, 4'b0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        drive_a(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_a(1, 1'b1, 16'h5000, 1'b1, 1'b0);
        @(negedge clk);
        expect_out("mrst1", 0, 4'b0010, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1);
        step();
        drive_a(1, 1'b1, 16'h5001, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("mrst2", 0, 4'b0010, 1'b1, 16'h5000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1);
        step();
        rst = 1'b0;
        drive_a(0, 1'b1, 16'h4444, 1'b1, 1'b1);
        drive_a(1, 1'b1, 16'h5002, 1'b0, 1'b0);
        @(negedge clk);
        expect_reset("mrst_hold", 0);
        step();
        rst = 1'b1;
        drive_a(0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_a(1, 1'b1, 16'h6000, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("mrst_rel", 0, 4'b0010, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        drive_a(1, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("mrst_new", 0, 4'b0000, 1'b1, 16'h6000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        @(negedge clk);
        expect_out("mrst_empty", 0, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();

        // Four ports: port1 moves rr_ptr to 2, then port3 flits wrap it to 0.
        drive_b(1, 1'b1, 16'h7100, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("p4_0", 1, 4'b0010, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();
        drive_b(1, 1'b0, 16'h0, 1'b0, 1'b0);
        drive_b(3, 1'b1, 16'h7300, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("p4_1", 1, 4'b1000, 1'b1, 16'h7100, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2);
        step();
        drive_b(3, 1'b1, 16'h7301, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("p4_2", 1, 4'b1000, 1'b1, 16'h7300, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        drive_b(3, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("p4_3", 1, 4'b0000, 1'b1, 16'h7301, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
        step();
        @(negedge clk);
        expect_out("p4_empty", 1, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dii_packet_arbiter.md
DII_PACKET_ARBITER -- requirements
Module: dii_packet_arbiter

Interface
REQ-001 Parameter PORTS, default 2, SHALL set the number of requesting DII input channels (range 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous, active-low.
REQ-004 in_flat_data  input  PORTS*16  SHALL carry per-port flit data; port i occupies bits [(i+1)*16-1:i*16].
REQ-005 in_flat_valid / in_flat_first / in_flat_last  input  PORTS each  SHALL carry per-port valid, first-flit and last-flit flags.
REQ-006 in_flat_ready  output  PORTS  SHALL carry per-port ready.
REQ-007 out_data  output  16  SHALL carry the arbitrated flit.
REQ-008 out_valid / out_first / out_last  output  1 each  SHALL carry the arbitrated valid and flags.
REQ-009 out_ready  input  1  SHALL carry downstream ready.
REQ-010 grant_port  output  $clog2(PORTS)  SHALL give the port currently holding the packet lock (valid only while locked).
REQ-011 locked  output  1  SHALL be high while a multi-flit packet is in progress.

Function
REQ-012 A flit SHALL transfer on any interface when valid and ready are both high in the same cycle.
REQ-013 The arbiter SHALL have two states: IDLE (no packet open) and LOCKED (packet open from port grant_port).
REQ-014 In IDLE the winner SHALL be the first port with in_flat_valid high, searching from rr_ptr upward with wrap-around from PORTS-1 to 0.
REQ-015 In LOCKED only grant_port SHALL be eligible; all other in_flat_ready SHALL be 0.
REQ-016 in_flat_ready[i] SHALL be high only for the eligible winner and only when the output register can accept (REQ-021).
REQ-017 IDLE->LOCKED SHALL occur on an input transfer with last=0; grant_port latches the winner index.
REQ-018 LOCKED->IDLE SHALL occur on an input transfer from grant_port with last=1.
REQ-019 A single-flit packet (first=1, last=1) SHALL transfer in IDLE without entering LOCKED.
REQ-020 On every input transfer with last=1, rr_ptr SHALL become (winner+1) mod PORTS; otherwise rr_ptr holds.
REQ-021 The output stage SHALL be one register slice: accepts when out_valid=0 or out_ready=1; full throughput of one flit per cycle when out_ready stays high.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle; data, first and last SHALL pass unmodified.
REQ-023 The first flag SHALL NOT affect arbitration; a flit without first in IDLE SHALL be treated as a packet start.
REQ-024 out_ready=0 while LOCKED SHALL stall the locked port only; lock and rr_ptr SHALL hold.
REQ-025 Valid on a non-granted port while LOCKED SHALL be held off without loss; inputs SHALL NOT be dropped or reordered.

Reset
REQ-026 Assertion of rst SHALL asynchronously force state=IDLE, rr_ptr=0, grant_port=0, locked=0, out_valid=0, out_first=0, out_last=0, out_data=0, in_flat_ready=0.
REQ-027 Reset mid-packet SHALL discard the open packet and the output register contents; no flit from before reset SHALL appear after release.
REQ-028 The first arbitration after reset release SHALL start from port 0.

Structure
REQ-029 The state enum (IDLE, LOCKED) and the flit width constant (16) SHALL live in the shared DII package next to dii_channel.
REQ-030 The output register slice SHALL be a separate sub-module dii_reg_slice (16-bit data, first, last, valid/ready).
REQ-031 The rotating priority search SHALL be a combinational function inside dii_packet_arbiter.

Verification
REQ-032 PORTS=2, both valid with single-flit packets continuously, out_ready=1 -> output alternates port0, port1, port0, ... one flit per cycle.
REQ-033 Port0 sends 4-flit packet 0x1000..0x1003 while port1 sends single flit 0x2000 -> 0x1000..0x1003 contiguous, then 0x2000; port1 ready=0 throughout LOCKED.
REQ-034 Port0 mid-packet, out_ready=0 for 3 cycles -> out_valid/out_data held constant, locked=1, grant_port=0, no flit lost.
REQ-035 PORTS=4, only port3 valid with single flits -> each flit appears 1 cycle after transfer; rr_ptr wraps to 0.
REQ-036 rst low for one cycle after flit 2 of a 5-flit packet -> all outputs 0 immediately; after release, a port1 flit wins with rr_ptr=0 and no stale flit appears.
